// File: rtl/bios_boot_loader.sv
// Boot-time copier: moves the 16 hardcoded BIOS words into instruction memory
// through a wr_en/wr_ack handshake and holds the CPU until the copy completes.
module bios_boot_loader #(
  parameter int NUM_WORDS = 16,
  parameter int ADDR_W    = 5,
  parameter int BASE_ADDR = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       b0I,
  input  logic [15:0]       b1I,
  input  logic [15:0]       b2I,
  input  logic [15:0]       b3I,
  input  logic [15:0]       b4I,
  input  logic [15:0]       b5I,
  input  logic [15:0]       b6I,
  input  logic [15:0]       b7I,
  input  logic [15:0]       b8I,
  input  logic [15:0]       b9I,
  input  logic [15:0]       b10I,
  input  logic [15:0]       b11I,
  input  logic [15:0]       b12I,
  input  logic [15:0]       b13I,
  input  logic [15:0]       b14I,
  input  logic [15:0]       b15I,
  input  logic              boot_req,
  input  logic              wr_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              cpu_hold,
  output logic              boot_done,
  output logic              done_pulse
);

  localparam int                IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COPY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              boot_done_q, boot_done_d;
  logic              done_pulse_q, done_pulse_d;

  logic [15:0]       bios_w [16];
  logic              accept;
  logic              load;

  assign bios_w[0]  = b0I;
  assign bios_w[1]  = b1I;
  assign bios_w[2]  = b2I;
  assign bios_w[3]  = b3I;
  assign bios_w[4]  = b4I;
  assign bios_w[5]  = b5I;
  assign bios_w[6]  = b6I;
  assign bios_w[7]  = b7I;
  assign bios_w[8]  = b8I;
  assign bios_w[9]  = b9I;
  assign bios_w[10] = b10I;
  assign bios_w[11] = b11I;
  assign bios_w[12] = b12I;
  assign bios_w[13] = b13I;
  assign bios_w[14] = b14I;
  assign bios_w[15] = b15I;

  // wr_ack only counts while a write is actually being offered.
  assign accept = wr_en_q & wr_ack;

  // NOTE: state and output registers use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_hold_q   <= 1'b1;
      boot_done_q  <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_hold_q   <= cpu_hold_d;
      boot_done_q  <= boot_done_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  // NOTE: every combinational output is defaulted first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_COPY;
        idx_d   = '0;
      end
      S_COPY: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (boot_req) begin
          state_d = S_COPY;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // A word is loaded when COPY is entered or when the current word is taken;
  // the BIOS input is sampled only at that point.
  assign load = (state_d == S_COPY) && ((state_q != S_COPY) || accept);

  always_comb begin
    wr_en_d      = wr_en_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    cpu_hold_d   = cpu_hold_q;
    boot_done_d  = boot_done_q;
    done_pulse_d = 1'b0;
    if (load) begin
      wr_en_d     = 1'b1;
      wr_addr_d   = BASE_A + ADDR_W'(idx_d);
      wr_data_d   = bios_w[idx_d];
      cpu_hold_d  = 1'b1;
      boot_done_d = 1'b0;
    end else if ((state_q == S_COPY) && (state_d == S_DONE)) begin
      wr_en_d      = 1'b0;
      cpu_hold_d   = 1'b0;
      boot_done_d  = 1'b1;
      done_pulse_d = 1'b1;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign boot_done  = boot_done_q;
  assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_bios_boot_loader.sv
// Bench for bios_boot_loader: two instances (base 16 and base 24) driven with
// shared directed and random stimulus, compared each cycle to a word-level model.
module tb_bios_boot_loader;

  logic        clock;
  logic        reset;
  logic        boot_req;
  logic        wr_ack;
  logic [15:0] bios [16];

  logic        en_a, hold_a, done_a, pulse_a;
  logic [4:0]  addr_a;
  logic [15:0] data_a;
  logic        en_b, hold_b, done_b, pulse_b;
  logic [4:0]  addr_b;
  logic [15:0] data_b;

  int checks = 0;
  int errors = 0;

  bios_boot_loader #(.NUM_WORDS(16), .ADDR_W(5), .BASE_ADDR(16)) dut (
    .clock(clock), .reset(reset),
    .b0I(bios[0]), .b1I(bios[1]), .b2I(bios[2]), .b3I(bios[3]),
    .b4I(bios[4]), .b5I(bios[5]), .b6I(bios[6]), .b7I(bios[7]),
    .b8I(bios[8]), .b9I(bios[9]), .b10I(bios[10]), .b11I(bios[11]),
    .b12I(bios[12]), .b13I(bios[13]), .b14I(bios[14]), .b15I(bios[15]),
    .boot_req(boot_req), .wr_ack(wr_ack),
    .wr_en(en_a), .wr_addr(addr_a), .wr_data(data_a),
    .cpu_hold(hold_a), .boot_done(done_a), .done_pulse(pulse_a)
  );

  bios_boot_loader #(.NUM_WORDS(16), .ADDR_W(5), .BASE_ADDR(24)) dut_wrap (
    .clock(clock), .reset(reset),
    .b0I(bios[0]), .b1I(bios[1]), .b2I(bios[2]), .b3I(bios[3]),
    .b4I(bios[4]), .b5I(bios[5]), .b6I(bios[6]), .b7I(bios[7]),
    .b8I(bios[8]), .b9I(bios[9]), .b10I(bios[10]), .b11I(bios[11]),
    .b12I(bios[12]), .b13I(bios[13]), .b14I(bios[14]), .b15I(bios[15]),
    .boot_req(boot_req), .wr_ack(wr_ack),
    .wr_en(en_b), .wr_addr(addr_b), .wr_data(data_b),
    .cpu_hold(hold_b), .boot_done(done_b), .done_pulse(pulse_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Word-level reference: which phase the loader is in, which word is on
  // offer, and what the outputs must look like.
  typedef enum {PH_RESET, PH_COPY, PH_DONE} phase_e;
  phase_e      m_phase;
  int          m_word;
  logic        m_en, m_hold, m_done, m_pulse;
  logic [4:0]  m_addr_a, m_addr_b;
  logic [15:0] m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_offer(input int w);
    m_phase  = PH_COPY;
    m_word   = w;
    m_en     = 1'b1;
    m_hold   = 1'b1;
    m_done   = 1'b0;
    m_addr_a = 5'((16 + w) % 32);
    m_addr_b = 5'((24 + w) % 32);
    m_data   = bios[w];
  endtask

  task automatic model_edge();
    m_pulse = 1'b0;
    if (reset) begin
      m_phase  = PH_RESET;
      m_word   = 0;
      m_en     = 1'b0;
      m_hold   = 1'b1;
      m_done   = 1'b0;
      m_addr_a = '0;
      m_addr_b = '0;
      m_data   = '0;
    end else if (m_phase == PH_RESET) begin
      model_offer(0);
    end else if (m_phase == PH_COPY) begin
      if (wr_ack) begin
        if (m_word == 15) begin
          m_phase = PH_DONE;
          m_en    = 1'b0;
          m_hold  = 1'b0;
          m_done  = 1'b1;
          m_pulse = 1'b1;
        end else begin
          model_offer(m_word + 1);
        end
      end
    end else if (boot_req) begin
      model_offer(0);
    end
  endtask

  // One clock: model follows the edge, then all outputs are compared 1ns later.
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check("wr_en",      {31'd0, en_a},    {31'd0, m_en});
    check("wr_addr",    {27'd0, addr_a},  {27'd0, m_addr_a});
    check("wr_data",    {16'd0, data_a},  {16'd0, m_data});
    check("cpu_hold",   {31'd0, hold_a},  {31'd0, m_hold});
    check("boot_done",  {31'd0, done_a},  {31'd0, m_done});
    check("done_pulse", {31'd0, pulse_a}, {31'd0, m_pulse});
    check("wrap_wr_en", {31'd0, en_b},    {31'd0, m_en});
    check("wrap_addr",  {27'd0, addr_b},  {27'd0, m_addr_b});
    check("wrap_data",  {16'd0, data_b},  {16'd0, m_data});
    check("wrap_hold",  {31'd0, hold_b},  {31'd0, m_hold});
    check("wrap_done",  {31'd0, done_b},  {31'd0, m_done});
    check("wrap_pulse", {31'd0, pulse_b}, {31'd0, m_pulse});
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  initial begin
    int en_cnt;
    reset    = 1'b1;
    boot_req = 1'b0;
    wr_ack   = 1'b0;
    for (int i = 0; i < 16; i++) bios[i] = 16'($urandom);
    bios[0]  = 16'h1120;
    bios[15] = 16'h0000;

    // Reset values, then an uninterrupted copy with ack tied high.
    do_reset(3);
    check("rst_hold", {31'd0, hold_a}, 32'd1);
    check("rst_addr", {27'd0, addr_a}, 32'd0);
    wr_ack = 1'b1;
    en_cnt = 0;
    for (int e = 1; e <= 18; e++) begin
      step();
      if (en_a) en_cnt++;
      if (e == 1) begin
        check("first_addr", {27'd0, addr_a}, 32'd16);
        check("first_data", {16'd0, data_a}, 32'h1120);
        check("first_wrap", {27'd0, addr_b}, 32'd24);
      end
      if (e == 9)  check("wrap_to_0", {27'd0, addr_b}, 32'd0);
      if (e == 16) begin
        check("last_addr", {27'd0, addr_a}, 32'd31);
        check("last_data", {16'd0, data_a}, 32'h0000);
        check("done_e16",  {31'd0, done_a}, 32'd0);
      end
      if (e == 17) begin
        check("done_e17",  {31'd0, done_a},  32'd1);
        check("pulse_e17", {31'd0, pulse_a}, 32'd1);
        check("hold_e17",  {31'd0, hold_a},  32'd0);
      end
      if (e == 18) check("pulse_e18", {31'd0, pulse_a}, 32'd0);
    end
    check("en_cycles", en_cnt, 32'd16);

    // Ack withheld for three cycles while word 5 is on offer.
    do_reset(2);
    for (int e = 1; e <= 21; e++) begin
      wr_ack = !(e >= 7 && e <= 9);
      step();
      if (e >= 7 && e <= 9) begin
        check("stall_addr", {27'd0, addr_a}, 32'd21);
        check("stall_data", {16'd0, data_a}, {16'd0, bios[5]});
      end
      if (e == 19) check("stall_done19", {31'd0, done_a}, 32'd0);
      if (e == 20) check("stall_done20", {31'd0, done_a}, 32'd1);
    end

    // Reset while word 9 is on offer restarts from word 0.
    wr_ack = 1'b1;
    do_reset(2);
    repeat (10) step();
    check("idx9_addr", {27'd0, addr_a}, 32'd25);
    reset = 1'b1;
    step();
    check("abort_en",   {31'd0, en_a},   32'd0);
    check("abort_hold", {31'd0, hold_a}, 32'd1);
    reset = 1'b0;
    step();
    check("restart_addr", {27'd0, addr_a}, 32'd16);
    check("restart_data", {16'd0, data_a}, {16'd0, bios[0]});
    repeat (17) step();

    // One-cycle boot_req in DONE triggers a full recopy.
    boot_req = 1'b1;
    step();
    boot_req = 1'b0;
    check("req_hold", {31'd0, hold_a}, 32'd1);
    check("req_done", {31'd0, done_a}, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 16) check("req_pulse", {31'd0, pulse_a}, 32'd1);
    end

    // boot_req held through a copy: no disturbance, then immediate restart.
    boot_req = 1'b1;
    step();
    for (int i = 1; i <= 16; i++) step();
    check("held_pulse", {31'd0, pulse_a}, 32'd1);
    step();
    check("held_restart", {31'd0, hold_a}, 32'd1);
    check("held_addr",    {27'd0, addr_a}, 32'd16);
    boot_req = 1'b0;

    // Random traffic: sporadic ack, boot_req, reset and BIOS word changes.
    for (int c = 0; c < 3000; c++) begin
      wr_ack   = ($urandom_range(0, 3) != 0);
      boot_req = ($urandom_range(0, 19) == 0);
      reset    = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) bios[$urandom_range(0, 15)] = 16'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bios_boot_loader.md
Name: bios_boot_loader

Overview:
- Boot-time copier between the 16-word hardcoded BIOS ROM and the writable instruction memory.
- After reset it copies BIOS words b0I..b15I into instruction memory at BASE_ADDR..BASE_ADDR+15, one word per write handshake.
- Holds the CPU (PC/fetch stall) until the copy completes, then releases it.
- Re-copy can be requested at runtime, e.g. a front-panel "reload BIOS" button.

Parameters:
- NUM_WORDS, 16, number of BIOS words copied; fixed by the BIOS ROM port count.
- ADDR_W, 5, instruction memory address width (32 words).
- BASE_ADDR, 16, destination address of b0I (BIOS occupies the high half).

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous active-high reset.
- b0I..b15I, input, 16 each, BIOS instruction words from the BIOS ROM.
- boot_req, input, 1, request re-copy; honoured only in DONE.
- wr_ack, input, 1, instruction memory accepted the current write.
- wr_en, output, 1, write request to instruction memory.
- wr_addr, output, ADDR_W, write address.
- wr_data, output, 16, write data.
- cpu_hold, output, 1, stalls PC/fetch while high.
- boot_done, output, 1, level; copy complete and CPU released.
- done_pulse, output, 1, one-cycle strobe on entry to DONE.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, idx=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, boot_done=0, done_pulse=0.
- reset has priority over every other input in every state.
- Reset mid-copy aborts the copy: IDLE, idx=0 on that edge. The copy restarts from word 0 once reset deasserts. Partial writes already made are not undone.
- IDLE: on the first edge with reset=0, go to COPY with idx=0. On that edge: wr_en=1, wr_addr=BASE_ADDR, wr_data=b0I, cpu_hold=1.
- COPY, handshake:
  - wr_en, wr_addr and wr_data are held stable until an edge where wr_en=1 and wr_ack=1.
  - wr_ack is ignored while wr_en=0.
  - With wr_ack low, wait indefinitely with outputs unchanged.
- COPY, accepted write with idx<NUM_WORDS-1: idx<=idx+1, wr_addr<=BASE_ADDR+idx+1 (modulo 2^ADDR_W), wr_data<=b(idx+1)I, wr_en stays 1. The ack cycle directly presents the next word; no bubble.
- COPY, accepted write with idx=NUM_WORDS-1: go to DONE. On that edge: wr_en=0, cpu_hold=0, boot_done=1, done_pulse=1.
- DONE:
  - done_pulse drops to 0 on the next edge.
  - boot_done stays 1 and cpu_hold stays 0 until boot_req or reset.
- DONE with boot_req=1 on an edge: go to COPY with idx=0. On that edge: wr_en=1, wr_addr=BASE_ADDR, wr_data=b0I, cpu_hold=1, boot_done=0.
- boot_req is ignored in IDLE and COPY. boot_req and reset both high: reset wins.
- Address wrap: BASE_ADDR+idx is truncated to ADDR_W bits. BASE_ADDR=24 writes 24..31, then 0..7.
- BIOS inputs are sampled when each word is loaded into wr_data. Changes to b*I after that do not affect the word in flight.
- Timing, wr_ack tied high:
  - wr_en is high for exactly 16 cycles.
  - boot_done rises on the 17th edge after reset deasserts.
  - cpu_hold is high for the whole reset period plus 16 cycles.

Test Plan:
- Reset, then release with wr_ack=1 and b0I=16'h1120, b15I=0 -> 16 consecutive writes at addresses 16..31. Data sequence is exactly b0I..b15I. boot_done=1 and done_pulse=1 for one cycle on edge 17; cpu_hold=0 thereafter.
- wr_ack low for 3 cycles on word 5 -> wr_addr=21 and wr_data=b5I held for those 3 cycles. No address skip. Total copy time is 19 cycles.
- Reset asserted while idx=9 -> next edge: wr_en=0, cpu_hold=1, boot_done=0. After release, writes restart at address 16 with b0I.
- In DONE, pulse boot_req for 1 cycle -> cpu_hold=1, boot_done=0, full 16-word copy repeats. Second done_pulse follows 16 cycles later with ack high.
- boot_req held high during COPY -> no restart and no change to sequence. In DONE, boot_req held high restarts the copy immediately on the next edge.
- BASE_ADDR=24 -> write addresses 24..31, then 0..7. wr_addr never exceeds 31.
